// File: rtl/wb_port_arbiter_if.sv
// Write-port arbitration bundle: pipeline and long-latency write requests,
// ID-stage hazard queries, and the resulting register file write port.
interface wb_port_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ll_issue;
  logic [4:0]  ll_issue_addr;
  logic        ll_valid;
  logic [4:0]  ll_waddr;
  logic [31:0] ll_wdata;
  logic        ll_ready;
  logic        id_re1;
  logic [4:0]  id_raddr1;
  logic        id_re2;
  logic [4:0]  id_raddr2;
  logic        id_we;
  logic [4:0]  id_waddr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hazard_stall;
  logic        starve_stall;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output ll_issue, ll_issue_addr,
    output ll_valid, ll_waddr, ll_wdata,
    input  ll_ready,
    output id_re1, id_raddr1, id_re2, id_raddr2, id_we, id_waddr,
    input  rf_we, rf_waddr, rf_wdata, hazard_stall, starve_stall
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  ll_issue, ll_issue_addr,
    input  ll_valid, ll_waddr, ll_wdata,
    output ll_ready,
    input  id_re1, id_raddr1, id_re2, id_raddr2, id_we, id_waddr,
    output rf_we, rf_waddr, rf_wdata, hazard_stall, starve_stall
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register file write port between the pipeline and
// long-latency results, tracks pending destinations and freezes on starvation.
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam logic [2:0] CNT_LAST = 3'(STARVE_MAX - 1);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [31:0] busy, busy_nx;
  logic        starve_q;
  logic        xfer;
  logic        raw1, raw2, waw;

  assign bus.ll_ready     = bus.ll_valid & ~bus.pipe_we & ~rst;
  assign xfer             = bus.ll_valid & bus.ll_ready;
  assign bus.starve_stall = starve_q;

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (!rst) begin
      if (bus.pipe_we) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.pipe_waddr;
        bus.rf_wdata = bus.pipe_wdata;
      end else if (bus.ll_valid) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.ll_waddr;
        bus.rf_wdata = bus.ll_wdata;
      end
    end
  end

  // Reads of a register being written back this cycle are forwarded by the
  // register file, so only the WAW term ignores the transfer.
  always_comb begin
    raw1 = bus.id_re1 && (bus.id_raddr1 != '0) && busy[bus.id_raddr1] &&
           !(xfer && (bus.ll_waddr == bus.id_raddr1));
    raw2 = bus.id_re2 && (bus.id_raddr2 != '0) && busy[bus.id_raddr2] &&
           !(xfer && (bus.ll_waddr == bus.id_raddr2));
    waw  = bus.id_we && (bus.id_waddr != '0) && busy[bus.id_waddr];
    bus.hazard_stall = !rst && (raw1 || raw2 || waw);
  end

  // Set is applied after clear so a same-address issue wins.
  always_comb begin
    busy_nx = busy;
    if (xfer)
      busy_nx[bus.ll_waddr] = 1'b0;
    if (bus.ll_issue && (bus.ll_issue_addr != '0))
      busy_nx[bus.ll_issue_addr] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.ll_valid && !bus.ll_ready) begin
          state_nx = WAIT;
          cnt_nx   = 3'd1;
        end else begin
          cnt_nx   = '0;
        end
      end
      WAIT: begin
        if (xfer || !bus.ll_valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
          if (cnt == CNT_LAST)
            state_nx = FORCE;
        end
      end
      FORCE: begin
        if (xfer || !bus.ll_valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= '0;
      starve_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      busy     <= busy_nx;
      starve_q <= (state_nx == FORCE);
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random checks of wb_port_arbiter against a cycle-level
// reference model built from the arbitration, scoreboard and starvation rules.
module tb_wb_port_arbiter;
  localparam int unsigned SM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus_if ();

  wb_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  bit          busy_m [32];
  int unsigned wait_m;
  bit          xfer_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.pipe_we = 1'b0;  bus_if.pipe_waddr = '0;  bus_if.pipe_wdata = '0;
    bus_if.ll_issue = 1'b0; bus_if.ll_issue_addr = '0;
    bus_if.ll_valid = 1'b0; bus_if.ll_waddr = '0;    bus_if.ll_wdata = '0;
    bus_if.id_re1 = 1'b0;   bus_if.id_raddr1 = '0;
    bus_if.id_re2 = 1'b0;   bus_if.id_raddr2 = '0;
    bus_if.id_we = 1'b0;    bus_if.id_waddr = '0;
  endtask

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    wait_m = 0;
    xfer_m = 1'b0;
  endtask

  function automatic bit read_hazard(input bit re, input logic [4:0] a, input bit xfer);
    return re && (a != 5'd0) && busy_m[a] && !(xfer && (bus_if.ll_waddr == a));
  endfunction

  // Sample at the falling edge and compare every output with the model.
  task automatic sample();
    logic        e_we, e_rdy, e_haz, e_starve;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    @(negedge clk);
    e_rdy = !rst && bus_if.ll_valid && !bus_if.pipe_we;
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if (!rst && bus_if.pipe_we) begin
      e_we = 1'b1; e_wa = bus_if.pipe_waddr; e_wd = bus_if.pipe_wdata;
    end else if (!rst && bus_if.ll_valid) begin
      e_we = 1'b1; e_wa = bus_if.ll_waddr; e_wd = bus_if.ll_wdata;
    end
    e_haz = !rst && (read_hazard(bus_if.id_re1, bus_if.id_raddr1, e_rdy) ||
                     read_hazard(bus_if.id_re2, bus_if.id_raddr2, e_rdy) ||
                     (bus_if.id_we && bus_if.id_waddr != 5'd0 && busy_m[bus_if.id_waddr]));
    e_starve = (wait_m >= SM);
    check("rf_we",        32'(bus_if.rf_we),        32'(e_we));
    check("rf_waddr",     32'(bus_if.rf_waddr),     32'(e_wa));
    check("rf_wdata",     bus_if.rf_wdata,          e_wd);
    check("ll_ready",     32'(bus_if.ll_ready),     32'(e_rdy));
    check("hazard_stall", 32'(bus_if.hazard_stall), 32'(e_haz));
    check("starve_stall", 32'(bus_if.starve_stall), 32'(e_starve));
    xfer_m = e_rdy;
  endtask

  // Apply the clock edge to the model, then release inputs for the next cycle.
  task automatic advance();
    if (rst) begin
      model_reset();
    end else begin
      if (xfer_m) busy_m[bus_if.ll_waddr] = 1'b0;
      if (bus_if.ll_issue && bus_if.ll_issue_addr != 5'd0) busy_m[bus_if.ll_issue_addr] = 1'b1;
      wait_m = (bus_if.ll_valid && !xfer_m) ? wait_m + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    bit prev_rst;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();
    step();
    sample();
    check("reset_rf_we", 32'(bus_if.rf_we), 32'd0);
    check("reset_starve", 32'(bus_if.starve_stall), 32'd0);
    advance();
    rst = 1'b0;

    // Pipeline beats long-latency in the same cycle, then the result drains.
    bus_if.ll_issue = 1'b1; bus_if.ll_issue_addr = 5'd5;
    step();
    idle_inputs();
    bus_if.pipe_we = 1'b1; bus_if.pipe_waddr = 5'd3; bus_if.pipe_wdata = 32'h11;
    bus_if.ll_valid = 1'b1; bus_if.ll_waddr = 5'd5; bus_if.ll_wdata = 32'h55;
    sample();
    check("pri_waddr", 32'(bus_if.rf_waddr), 32'd3);
    check("pri_wdata", bus_if.rf_wdata, 32'h11);
    check("pri_ready", 32'(bus_if.ll_ready), 32'd0);
    advance();
    bus_if.pipe_we = 1'b0;
    sample();
    check("ll_waddr", 32'(bus_if.rf_waddr), 32'd5);
    check("ll_ready1", 32'(bus_if.ll_ready), 32'd1);
    advance();
    idle_inputs();
    bus_if.id_re1 = 1'b1; bus_if.id_raddr1 = 5'd5;
    sample();
    check("busy5_clear", 32'(bus_if.hazard_stall), 32'd0);
    advance();

    // RAW on a pending destination, forwarding on transfer, WAW not forwarded.
    idle_inputs();
    bus_if.ll_issue = 1'b1; bus_if.ll_issue_addr = 5'd7;
    step();
    idle_inputs();
    bus_if.id_re1 = 1'b1; bus_if.id_raddr1 = 5'd7;
    sample();
    check("raw7", 32'(bus_if.hazard_stall), 32'd1);
    advance();
    bus_if.ll_valid = 1'b1; bus_if.ll_waddr = 5'd7; bus_if.ll_wdata = 32'h77;
    sample();
    check("raw7_fwd", 32'(bus_if.hazard_stall), 32'd0);
    advance();
    idle_inputs();
    bus_if.ll_issue = 1'b1; bus_if.ll_issue_addr = 5'd7;
    step();
    idle_inputs();
    bus_if.ll_valid = 1'b1; bus_if.ll_waddr = 5'd7; bus_if.ll_wdata = 32'h78;
    bus_if.id_re1 = 1'b1; bus_if.id_raddr1 = 5'd7;
    bus_if.id_we = 1'b1;  bus_if.id_waddr = 5'd7;
    sample();
    check("waw7", 32'(bus_if.hazard_stall), 32'd1);
    advance();

    // Issue and transfer of the same register in one cycle leaves it busy.
    idle_inputs();
    bus_if.ll_issue = 1'b1; bus_if.ll_issue_addr = 5'd9;
    bus_if.ll_valid = 1'b1; bus_if.ll_waddr = 5'd9; bus_if.ll_wdata = 32'h99;
    step();
    idle_inputs();
    bus_if.id_re2 = 1'b1; bus_if.id_raddr2 = 5'd9;
    sample();
    check("busy9_kept", 32'(bus_if.hazard_stall), 32'd1);
    advance();

    // Register zero is never tracked.
    idle_inputs();
    bus_if.ll_issue = 1'b1; bus_if.ll_issue_addr = 5'd0;
    step();
    idle_inputs();
    bus_if.id_re1 = 1'b1; bus_if.id_raddr1 = 5'd0;
    bus_if.id_we = 1'b1;  bus_if.id_waddr = 5'd0;
    sample();
    check("r0_nohaz", 32'(bus_if.hazard_stall), 32'd0);
    advance();

    // Starvation: freeze after SM denied cycles, release after transfer.
    idle_inputs();
    bus_if.pipe_we = 1'b1; bus_if.pipe_waddr = 5'd1; bus_if.pipe_wdata = 32'hA5;
    bus_if.ll_valid = 1'b1; bus_if.ll_waddr = 5'd6; bus_if.ll_wdata = 32'h66;
    for (int k = 0; k <= int'(SM); k++) begin
      sample();
      check("starve_rise", 32'(bus_if.starve_stall), 32'(k >= int'(SM)));
      advance();
    end
    bus_if.pipe_we = 1'b0;
    sample();
    check("starve_xfer_ready", 32'(bus_if.ll_ready), 32'd1);
    advance();
    idle_inputs();
    sample();
    check("starve_fall", 32'(bus_if.starve_stall), 32'd0);
    advance();

    // Reset while frozen with a pending destination.
    bus_if.ll_issue = 1'b1; bus_if.ll_issue_addr = 5'd4;
    step();
    idle_inputs();
    bus_if.pipe_we = 1'b1; bus_if.pipe_waddr = 5'd2; bus_if.pipe_wdata = 32'h22;
    bus_if.ll_valid = 1'b1; bus_if.ll_waddr = 5'd8; bus_if.ll_wdata = 32'h88;
    for (int k = 0; k <= int'(SM); k++) step();
    rst = 1'b1;
    bus_if.id_re1 = 1'b1; bus_if.id_raddr1 = 5'd4;
    sample();
    check("rst_rf_we", 32'(bus_if.rf_we), 32'd0);
    check("rst_ready", 32'(bus_if.ll_ready), 32'd0);
    check("rst_haz", 32'(bus_if.hazard_stall), 32'd0);
    advance();
    rst = 1'b0;
    idle_inputs();
    bus_if.id_re1 = 1'b1; bus_if.id_raddr1 = 5'd4;
    sample();
    check("rst_busy4", 32'(bus_if.hazard_stall), 32'd0);
    check("rst_starve", 32'(bus_if.starve_stall), 32'd0);
    advance();

    // Random traffic; a long-latency result is held until it transfers.
    idle_inputs();
    prev_rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (!bus_if.ll_valid || xfer_m || prev_rst) begin
        bus_if.ll_valid = ($urandom_range(0, 2) != 0);
        bus_if.ll_waddr = 5'($urandom_range(0, 15));
        bus_if.ll_wdata = $urandom;
      end
      bus_if.pipe_we       = ($urandom_range(0, 9) < 7);
      bus_if.pipe_waddr    = 5'($urandom);
      bus_if.pipe_wdata    = $urandom;
      bus_if.ll_issue      = ($urandom_range(0, 3) == 0);
      bus_if.ll_issue_addr = 5'($urandom_range(0, 15));
      bus_if.id_re1        = 1'($urandom);
      bus_if.id_raddr1     = 5'($urandom_range(0, 15));
      bus_if.id_re2        = 1'($urandom);
      bus_if.id_raddr2     = 5'($urandom_range(0, 15));
      bus_if.id_we         = 1'($urandom);
      bus_if.id_waddr      = 5'($urandom_range(0, 15));
      prev_rst = rst;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, cycles a long-latency result may be denied the write port before the pipeline is frozen; legal range 2..7.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pipe_we / pipe_waddr / pipe_wdata  input  1/5/32  MEM/WB-stage write request.
REQ-005 ll_issue / ll_issue_addr  input  1/5  long-latency (divider/load) op issued, destination register.
REQ-006 ll_valid / ll_waddr / ll_wdata  input  1/5/32  long-latency result offered.
REQ-007 ll_ready  output  1  long-latency result accepted this cycle.
REQ-008 id_re1 / id_raddr1 / id_re2 / id_raddr2  input  1/5/1/5  ID-stage source reads.
REQ-009 id_we / id_waddr  input  1/5  ID-stage instruction destination.
REQ-010 rf_we / rf_waddr / rf_wdata  output  1/5/32  register file write port.
REQ-011 hazard_stall  output  1  ID must stall (RAW/WAW on a pending long-latency destination).
REQ-012 starve_stall  output  1  registered request to freeze the pipeline so the write port frees.

Function
REQ-013 Port arbitration is combinational: pipe_we=1 -> rf_* driven from pipe_*; else ll_valid=1 -> rf_* driven from ll_*; else rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-014 ll_ready = ll_valid & ~pipe_we & ~rst; transfer occurs in a cycle where ll_valid=1 and ll_ready=1; ll_valid, ll_waddr and ll_wdata must hold until transfer.
REQ-015 Pipeline write always has priority; it is never dropped or delayed.
REQ-016 Busy scoreboard: 32-bit register busy[31:0]; bit 0 permanently 0.
REQ-017 ll_issue=1 with ll_issue_addr!=0 sets busy[ll_issue_addr] at next edge.
REQ-018 A transfer clears busy[ll_waddr] at next edge; simultaneous set and clear of the same address leaves the bit set.
REQ-019 hazard_stall=1 when any: id_re1 & id_raddr1!=0 & busy[id_raddr1]; id_re2 & id_raddr2!=0 & busy[id_raddr2]; id_we & id_waddr!=0 & busy[id_waddr].
REQ-020 A busy source being written by a transfer in the same cycle does not raise hazard_stall for that read (register file forwards the write data); the WAW term is not suppressed.
REQ-021 FSM states IDLE, WAIT, FORCE; 3-bit counter cnt.
REQ-022 IDLE: ll_valid & ~ll_ready -> WAIT, cnt=1; otherwise stay, cnt=0.
REQ-023 WAIT: transfer -> IDLE, cnt=0; ll_valid=0 -> IDLE, cnt=0; else cnt+1, and when cnt reaches STARVE_MAX-1 -> FORCE.
REQ-024 FORCE: starve_stall=1 (registered, asserted the first cycle in FORCE); transfer -> IDLE and starve_stall=0 next cycle; ll_valid=0 -> IDLE.
REQ-025 starve_stall is 0 in IDLE and WAIT.
REQ-026 Writes to address 0 pass to rf_* unchanged; register file discards them.

Reset
REQ-027 rst=1 at an edge: state IDLE, cnt=0, busy all 0, starve_stall=0.
REQ-028 While rst=1: rf_we=0, ll_ready=0, hazard_stall=0 regardless of inputs.
REQ-029 rst asserted mid-WAIT/FORCE aborts pending arbitration; no write is issued that cycle.

Verification
REQ-030 pipe_we=1 waddr=3 data=0x11, ll_valid=1 waddr=5 same cycle -> rf writes r3=0x11, ll_ready=0; next cycle pipe_we=0 -> rf writes r5, ll_ready=1, busy[5] cleared.
REQ-031 ll_issue addr 7; next cycle id_re1=1 raddr1=7 -> hazard_stall=1; cycle of transfer to r7 -> hazard_stall=0; id_we=1 waddr=7 in same cycle -> hazard_stall=1.
REQ-032 STARVE_MAX=4, ll_valid held with pipe_we=1 continuously -> starve_stall rises in the 4th cycle after ll_valid; drop pipe_we -> transfer, starve_stall=0 next cycle.
REQ-033 ll_issue addr 9 and transfer to r9 same cycle -> busy[9]=1 afterwards.
REQ-034 ll_issue addr 0 -> busy stays 0; id_re1 raddr1=0 -> hazard_stall=0.
REQ-035 rst pulsed while in FORCE with busy[4]=1 -> state IDLE, busy=0, starve_stall=0, rf_we=0 during rst.
